// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Purpose  : Four-requester round-robin packet arbiter driving a shared
//            W-bit 4:1 datapath into a one-entry registered output slice.
//            A grant is held for a whole packet (until in_last or MAX_BEATS
//            beats), so beats from different sources never interleave.
// Ports    : clk, rst_n            - clock, async active-low reset
//            in_valid/in_last[3:0] - per-requester handshake and end-of-packet
//            in_data0..in_data3    - per-requester beat data
//            in_ready[3:0]         - per-requester accept (combinational)
//            out_valid/out_ready   - downstream handshake
//            out_data/out_last/out_src - registered beat, EOP flag, source id
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int W         = 4,
    parameter int MAX_BEATS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    input  logic [3:0]   in_last,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic [3:0]   in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic [1:0]   out_src,
    input  logic         out_ready
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Beat-count value at which the accepted beat is forced to end the grant.
    localparam logic [7:0] LAST_BEAT_IDX = 8'(MAX_BEATS - 1);

    state_t       r_state;
    logic [1:0]   r_grant;
    logic [1:0]   r_ptr;
    logic [7:0]   r_beat_cnt;

    logic         w_slot_free;
    logic         w_accept;
    logic         w_release;
    logic [1:0]   w_pick;
    logic [W-1:0] w_grant_data;

    // The output slice can take a beat when empty or draining this cycle.
    assign w_slot_free = !out_valid || out_ready;
    assign w_accept    = (r_state == BUSY) && in_valid[r_grant] && w_slot_free;
    assign w_release   = in_last[r_grant] || (r_beat_cnt == LAST_BEAT_IDX);

    always_comb begin
        in_ready = 4'b0000;
        if ((r_state == BUSY) && w_slot_free) begin
            in_ready[r_grant] = 1'b1;
        end
    end

    always_comb begin
        unique case (r_grant)
            2'd0:    w_grant_data = in_data0;
            2'd1:    w_grant_data = in_data1;
            2'd2:    w_grant_data = in_data2;
            default: w_grant_data = in_data3;
        endcase
    end

    // Rotating priority search starting at r_ptr; the first hit wins.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        found  = 1'b0;
        w_pick = r_ptr;
        for (int k = 0; k < 4; k++) begin
            idx = r_ptr + k[1:0];
            if (!found && in_valid[idx]) begin
                found  = 1'b1;
                w_pick = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= 2'd0;
            r_ptr      <= 2'd0;
            r_beat_cnt <= 8'd0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_src    <= 2'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (|in_valid) begin
                        r_grant    <= w_pick;
                        r_beat_cnt <= 8'd0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (w_release) begin
                            r_state <= IDLE;
                            r_ptr   <= r_grant + 2'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Load has priority over drain so back-to-back beats keep valid high.
            if (w_accept) begin
                out_valid <= 1'b1;
                out_data  <= w_grant_data;
                out_last  <= w_release;
                out_src   <= r_grant;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Purpose  : Scoreboard bench for mux4_rr_arbiter. Per-requester source
//            queues feed the DUT; expected output beats are queued when the
//            stimulus is issued and a monitor compares each delivered beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

    typedef struct packed {
        logic [7:0] gap;    // idle cycles before this beat is presented
        logic [3:0] d;
        logic       l;
    } beat_t;

    typedef struct packed {
        logic [3:0] d;
        logic       l;
        logic [1:0] s;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [3:0] in_last;
    logic [3:0] dat [4];
    logic [3:0] in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_last;
    logic [1:0] out_src;
    logic       out_ready;

    beat_t sq [4][$];
    exp_t  exp_q [$];
    int    out_cyc [$];
    logic [3:0] present;
    logic [3:0] acc_r;
    int    waitc [4];
    int    cyc;
    int    n_tests;
    int    n_fail;

    mux4_rr_arbiter #(.W(4), .MAX_BEATS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_data0 (dat[0]),
        .in_data1 (dat[1]),
        .in_data2 (dat[2]),
        .in_data3 (dat[3]),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_src  (out_src),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_beat(input int s, input int gap, input logic [3:0] d, input logic l);
        beat_t b;
        b.gap = 8'(gap);
        b.d   = d;
        b.l   = l;
        sq[s].push_back(b);
    endtask

    task automatic push_exp(input logic [3:0] d, input logic l, input logic [1:0] s);
        exp_t e;
        e.d = d;
        e.l = l;
        e.s = s;
        exp_q.push_back(e);
    endtask

    task automatic clear_tb();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            sq[i].delete();
            waitc[i] = 0;
            dat[i]   = 4'h0;
        end
        present  = 4'b0000;
        acc_r    = 4'b0000;
        in_valid = 4'b0000;
        in_last  = 4'b0000;
    endtask

    function automatic bit all_idle();
        bit r;
        r = (exp_q.size() == 0) && (present == 4'b0000);
        for (int i = 0; i < 4; i++) if (sq[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_done(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            done = all_idle();
        end
        if (!done) check({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        clear_tb();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    // Monitor: sample between edges; records acceptances for the sources and
    // scores every delivered output beat.
    always @(negedge clk) begin
        if (rst_n) begin
            acc_r = in_valid & in_ready;
            if (out_valid && out_ready) begin
                out_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'({out_data, out_last, out_src}), 32'h7f);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("beat", 32'({out_data, out_last, out_src}), 32'({e.d, e.l, e.s}));
                end
            end
        end
    end

    // Source drivers: present the queue head, pop on acceptance.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (present[i] && acc_r[i]) begin
                void'(sq[i].pop_front());
                present[i] = 1'b0;
                waitc[i]   = 0;
            end
            if (!present[i] && sq[i].size() > 0) begin
                if (waitc[i] >= int'(sq[i][0].gap)) present[i] = 1'b1;
                else waitc[i]++;
            end
            in_valid[i] = present[i];
            in_last[i]  = present[i] ? sq[i][0].l : 1'b0;
            dat[i]      = present[i] ? sq[i][0].d : 4'h0;
        end
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        clear_tb();

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_out_src",   32'(out_src),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        // Single source: requester 2, beats A,B,C
        push_beat(2, 0, 4'hA, 1'b0);
        push_beat(2, 0, 4'hB, 1'b0);
        push_beat(2, 0, 4'hC, 1'b1);
        push_exp(4'hA, 1'b0, 2'd2);
        push_exp(4'hB, 1'b0, 2'd2);
        push_exp(4'hC, 1'b1, 2'd2);
        out_cyc.delete();
        #2;
        check("t1_valid_before_ready", 32'({in_valid[2], in_ready[2]}), 32'b10);
        @(posedge clk);
        #2;
        check("t1_ready_rise", 32'(in_ready), 32'b0100);
        wait_done("t1", 50);
        check("t1_beats_back_to_back",
              (out_cyc.size() == 3) ? 32'(out_cyc[2] - out_cyc[0]) : 32'hffff, 32'd2);

        // Round robin: all four requesting 1-beat packets
        do_reset();
        out_cyc.delete();
        push_beat(0, 0, 4'h1, 1'b1);
        push_beat(0, 0, 4'h5, 1'b1);
        push_beat(1, 0, 4'h2, 1'b1);
        push_beat(1, 0, 4'h6, 1'b1);
        push_beat(2, 0, 4'h3, 1'b1);
        push_beat(3, 0, 4'h4, 1'b1);
        push_exp(4'h1, 1'b1, 2'd0);
        push_exp(4'h2, 1'b1, 2'd1);
        push_exp(4'h3, 1'b1, 2'd2);
        push_exp(4'h4, 1'b1, 2'd3);
        push_exp(4'h5, 1'b1, 2'd0);
        push_exp(4'h6, 1'b1, 2'd1);
        wait_done("t2", 100);
        check("t2_beat_count", 32'(out_cyc.size()), 32'd6);
        for (int k = 1; k < out_cyc.size(); k++)
            check("t2_idle_bubble", 32'(out_cyc[k] - out_cyc[k-1]), 32'd2);

        // Backpressure: source 1, 4 beats, 3-cycle stall
        push_beat(1, 0, 4'h1, 1'b0);
        push_beat(1, 0, 4'h2, 1'b0);
        push_beat(1, 0, 4'h3, 1'b0);
        push_beat(1, 0, 4'h4, 1'b1);
        push_exp(4'h1, 1'b0, 2'd1);
        push_exp(4'h2, 1'b0, 2'd1);
        push_exp(4'h3, 1'b0, 2'd1);
        push_exp(4'h4, 1'b1, 2'd1);
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                seen = out_valid;
            end
            if (!seen) check("t3_first_beat_timeout", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("t3_stall_valid", 32'(out_valid), 32'd1);
            check("t3_stall_data", 32'(out_data), 32'h2);
            check("t3_stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done("t3", 50);

        // Forced release after 8 beats; source 3 gets a turn in between
        do_reset();
        for (int k = 0; k < 10; k++) push_beat(0, 0, 4'(k), 1'b0);
        push_beat(3, 0, 4'hF, 1'b1);
        for (int k = 0; k < 8; k++) push_exp(4'(k), (k == 7), 2'd0);
        push_exp(4'hF, 1'b1, 2'd3);
        push_exp(4'h8, 1'b0, 2'd0);
        push_exp(4'h9, 1'b0, 2'd0);
        wait_done("t4", 100);

        // No interleave: source 0 gaps 2 cycles mid-packet while source 1 waits
        do_reset();
        push_beat(0, 0, 4'h1, 1'b0);
        push_beat(0, 0, 4'h2, 1'b0);
        push_beat(0, 2, 4'h3, 1'b1);
        push_beat(1, 0, 4'hB, 1'b1);
        push_exp(4'h1, 1'b0, 2'd0);
        push_exp(4'h2, 1'b0, 2'd0);
        push_exp(4'h3, 1'b1, 2'd0);
        push_exp(4'hB, 1'b1, 2'd1);
        wait_done("t5", 60);

        // Reset mid-operation with output stalled and grant active
        out_ready = 1'b0;
        push_beat(2, 0, 4'h1, 1'b0);
        push_beat(2, 0, 4'h2, 1'b0);
        push_beat(2, 0, 4'h3, 1'b1);
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                seen = out_valid;
            end
            if (!seen) check("t6_valid_timeout", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_out_valid", 32'(out_valid), 32'd0);
        check("t6_async_in_ready", 32'(in_ready), 32'd0);
        check("t6_async_out_data", 32'(out_data), 32'd0);
        clear_tb();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            push_beat(i, 0, 4'(8 + i), 1'b1);
            push_exp(4'(8 + i), 1'b1, 2'(i));
        end
        wait_done("t6", 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
